// File: rtl/qkd_host_req_sched.sv
// Host-request scheduler: polls the mailbox status word and sequences the
// initial BRAM load, round-robin key reads / input writes and the READY/IDLE handshake.
module qkd_host_req_sched #(
    parameter int NUM_KEY_CH     = 2,
    parameter int NUM_IN_CH      = 4,
    parameter int FIELD_W        = 4,
    parameter logic [FIELD_W-1:0] IDLE_CODE    = 'h0,
    parameter logic [FIELD_W-1:0] REQUEST_CODE = 'h1,
    parameter logic [FIELD_W-1:0] WRITER_CODE  = 'h2,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int END_AFTER_KEYS = 2,
    localparam int SW = FIELD_W * (1 + NUM_KEY_CH + NUM_IN_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  init_load_done,
    input  logic [SW-1:0]         status_in,
    input  logic [NUM_KEY_CH-1:0] key_read_done,
    input  logic [NUM_IN_CH-1:0]  in_write_done,
    output logic                  init_load_en,
    output logic [NUM_KEY_CH-1:0] key_read_en,
    output logic [NUM_IN_CH-1:0]  in_write_en,
    output logic                  write_ready_en,
    output logic                  write_idle_en,
    output logic                  reset_cnt,
    output logic                  timeout_err,
    output logic [7:0]            keys_read,
    output logic [4:0]            sched_state
);

    localparam int NUM_FIELDS = 1 + NUM_KEY_CH + NUM_IN_CH;
    localparam int KW = (NUM_KEY_CH > 1) ? $clog2(NUM_KEY_CH) : 1;
    localparam int IW = (NUM_IN_CH > 1) ? $clog2(NUM_IN_CH) : 1;
    localparam logic [31:0] TMO_LIM = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_KEY_CH-1:0] KEY_ONE = 1;
    localparam logic [NUM_IN_CH-1:0]  IN_ONE  = 1;

    typedef enum logic [4:0] {
        S_IDLE         = 5'd0,
        S_START        = 5'd1,
        S_INIT_LOAD    = 5'd2,
        S_INIT_END     = 5'd3,
        S_INIT_IDLE_WR = 5'd4,
        S_POLL         = 5'd5,
        S_KEY_READ     = 5'd6,
        S_KEY_END      = 5'd7,
        S_IN_WRITE     = 5'd8,
        S_IN_END       = 5'd9,
        S_WR_READY     = 5'd10,
        S_WAIT_IDLE    = 5'd11,
        S_WR_IDLE      = 5'd12,
        S_FINISH       = 5'd13,
        S_TEST_END     = 5'd30,
        S_ERROR        = 5'd31
    } state_t;

    state_t state, state_next;

    logic [KW-1:0]         key_ptr, key_grant;
    logic [IW-1:0]         in_ptr, in_grant;
    logic [NUM_KEY_CH-1:0] key_req;
    logic [NUM_IN_CH-1:0]  in_req;
    logic                  key_any, in_any;
    logic                  mailbox_idle;
    logic [31:0]           tmo_cnt;
    logic                  tmo_hit;
    logic [7:0]            keys_inc;
    logic                  end_hit;

    // First requesting index strictly after ptr, wrapping modulo n (n <= 8).
    function automatic int rr_pick(input logic [7:0] req, input int ptr, input int n);
        int pick;
        int idx;
        pick = ptr;
        idx  = 0;
        for (int off = 8; off >= 1; off--) begin
            if (off <= n) begin
                idx = (ptr + off) % n;
                if (req[idx[2:0]]) pick = idx;
            end
        end
        return pick;
    endfunction

    function automatic logic is_wait(input state_t s);
        return (s == S_INIT_LOAD) || (s == S_KEY_READ) ||
               (s == S_IN_WRITE)  || (s == S_WAIT_IDLE);
    endfunction

    always_comb begin
        key_req      = '0;
        in_req       = '0;
        mailbox_idle = (status_in[FIELD_W-1:0] == WRITER_CODE);
        for (int k = 0; k < NUM_KEY_CH; k++)
            key_req[k] = (status_in[FIELD_W*(1+k) +: FIELD_W] == REQUEST_CODE);
        for (int i = 0; i < NUM_IN_CH; i++)
            in_req[i] = (status_in[FIELD_W*(1+NUM_KEY_CH+i) +: FIELD_W] == REQUEST_CODE);
        for (int f = 1; f < NUM_FIELDS; f++)
            if (status_in[FIELD_W*f +: FIELD_W] != IDLE_CODE) mailbox_idle = 1'b0;
    end

    assign key_any   = |key_req;
    assign in_any    = |in_req;
    assign key_grant = KW'(rr_pick(8'(key_req), int'(key_ptr), NUM_KEY_CH));
    assign in_grant  = IW'(rr_pick(8'(in_req), int'(in_ptr), NUM_IN_CH));

    assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (tmo_cnt >= TMO_LIM);
    assign keys_inc = (keys_read == 8'hFF) ? 8'hFF : keys_read + 8'd1;
    assign end_hit  = (END_AFTER_KEYS != 0) && (int'(keys_inc) >= END_AFTER_KEYS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Exit conditions are tested before the timeout so a same-cycle done wins.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:         if (start) state_next = S_START;
            S_START:        state_next = S_INIT_LOAD;
            S_INIT_LOAD: begin
                if (init_load_done) state_next = S_INIT_END;
                else if (tmo_hit)   state_next = S_ERROR;
            end
            S_INIT_END:     state_next = S_INIT_IDLE_WR;
            S_INIT_IDLE_WR: state_next = S_POLL;
            S_POLL: begin
                if (key_any)     state_next = S_KEY_READ;
                else if (in_any) state_next = S_IN_WRITE;
            end
            S_KEY_READ: begin
                if (key_read_done[key_ptr]) state_next = S_KEY_END;
                else if (tmo_hit)           state_next = S_ERROR;
            end
            S_KEY_END: begin
                if (end_hit)     state_next = S_TEST_END;
                else if (in_any) state_next = S_IN_WRITE;
                else             state_next = S_WR_READY;
            end
            S_IN_WRITE: begin
                if (in_write_done[in_ptr]) state_next = S_IN_END;
                else if (tmo_hit)          state_next = S_ERROR;
            end
            S_IN_END:       state_next = S_WR_READY;
            S_WR_READY:     state_next = S_WAIT_IDLE;
            S_WAIT_IDLE: begin
                if (mailbox_idle) state_next = S_WR_IDLE;
                else if (tmo_hit) state_next = S_ERROR;
            end
            S_WR_IDLE:      state_next = S_FINISH;
            S_FINISH:       state_next = S_IDLE;
            S_TEST_END:     state_next = S_TEST_END;
            S_ERROR:        state_next = S_ERROR;
            default:        state_next = S_ERROR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_ptr   <= KW'(NUM_KEY_CH - 1);
            in_ptr    <= IW'(NUM_IN_CH - 1);
            tmo_cnt   <= '0;
            keys_read <= '0;
        end else begin
            if (state_next == S_KEY_READ && state != S_KEY_READ) key_ptr <= key_grant;
            if (state_next == S_IN_WRITE && state != S_IN_WRITE) in_ptr  <= in_grant;
            if (is_wait(state_next) && state_next != state) tmo_cnt <= '0;
            else if (is_wait(state))                        tmo_cnt <= tmo_cnt + 32'd1;
            if (state == S_KEY_END) keys_read <= keys_inc;
        end
    end

    always_comb begin
        init_load_en   = (state == S_INIT_LOAD);
        key_read_en    = (state == S_KEY_READ) ? (KEY_ONE << key_ptr) : '0;
        in_write_en    = (state == S_IN_WRITE) ? (IN_ONE << in_ptr) : '0;
        write_ready_en = (state == S_WR_READY);
        write_idle_en  = (state == S_INIT_IDLE_WR) || (state == S_WR_IDLE);
        reset_cnt      = (state == S_FINISH);
        timeout_err    = (state == S_ERROR);
        sched_state    = state;
    end

endmodule

// File: tb/tb_qkd_host_req_sched.sv
// Directed bench for qkd_host_req_sched: a cycle-by-cycle vector table plus
// hand-written sequences for key priority, timeouts and asynchronous reset.
module tb_qkd_host_req_sched;

    localparam int NK = 2;
    localparam int NI = 4;
    localparam int SW = 28;

    localparam logic [27:0] ST_NONE  = 28'h0000000;
    localparam logic [27:0] ST_BOTH  = 28'h0000112;
    localparam logic [27:0] ST_WIDLE = 28'h0000002;
    localparam logic [27:0] ST_WBUSY = 28'h0000012;
    localparam logic [27:0] ST_PRIO  = 28'h1000012;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          init_load_done;
    logic [SW-1:0] status_in;
    logic [NK-1:0] key_read_done;
    logic [NI-1:0] in_write_done;
    logic          init_load_en;
    logic [NK-1:0] key_read_en;
    logic [NI-1:0] in_write_en;
    logic          write_ready_en;
    logic          write_idle_en;
    logic          reset_cnt;
    logic          timeout_err;
    logic [7:0]    keys_read;
    logic [4:0]    sched_state;

    int applied     = 0;
    int miscompares = 0;

    typedef struct {
        logic        start;
        logic        ild;
        logic [27:0] status;
        logic [1:0]  kd;
        logic [3:0]  id;
        logic [4:0]  st;
        logic [1:0]  ken;
        logic [3:0]  ien;
        logic        ilen;
        logic        rdy;
        logic        idl;
        logic        rc;
        logic [7:0]  kr;
        logic        te;
    } vec_t;

    vec_t tbl[$];

    qkd_host_req_sched #(
        .NUM_KEY_CH(NK),
        .NUM_IN_CH(NI),
        .FIELD_W(4),
        .TIMEOUT_CYCLES(16),
        .END_AFTER_KEYS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .init_load_done(init_load_done),
        .status_in(status_in),
        .key_read_done(key_read_done),
        .in_write_done(in_write_done),
        .init_load_en(init_load_en),
        .key_read_en(key_read_en),
        .in_write_en(in_write_en),
        .write_ready_en(write_ready_en),
        .write_idle_en(write_idle_en),
        .reset_cnt(reset_cnt),
        .timeout_err(timeout_err),
        .keys_read(keys_read),
        .sched_state(sched_state)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic s, input logic ild, input logic [27:0] status,
                                input logic [1:0] kd, input logic [3:0] id, input logic [4:0] st,
                                input logic [1:0] ken, input logic [3:0] ien, input logic ilen,
                                input logic rdy, input logic idl, input logic rc,
                                input logic [7:0] kr, input logic te);
        vec_t v;
        v.start = s;   v.ild = ild; v.status = status; v.kd = kd; v.id = id;
        v.st = st;     v.ken = ken; v.ien = ien; v.ilen = ilen; v.rdy = rdy;
        v.idl = idl;   v.rc = rc;   v.kr = kr; v.te = te;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        start          = v.start;
        init_load_done = v.ild;
        status_in      = v.status;
        key_read_done  = v.kd;
        in_write_done  = v.id;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input vec_t v, input string name);
        applied++;
        if (sched_state !== v.st || key_read_en !== v.ken || in_write_en !== v.ien ||
            init_load_en !== v.ilen || write_ready_en !== v.rdy || write_idle_en !== v.idl ||
            reset_cnt !== v.rc || keys_read !== v.kr || timeout_err !== v.te) begin
            miscompares++;
            $display("[TB] FAIL %s: got st=%0d ken=%b ien=%b ilen=%b rdy=%b idl=%b rc=%b kr=%0d te=%b, expected st=%0d ken=%b ien=%b ilen=%b rdy=%b idl=%b rc=%b kr=%0d te=%b",
                     name, sched_state, key_read_en, in_write_en, init_load_en, write_ready_en,
                     write_idle_en, reset_cnt, keys_read, timeout_err,
                     v.st, v.ken, v.ien, v.ilen, v.rdy, v.idl, v.rc, v.kr, v.te);
        end
    endtask

    task automatic step(input vec_t v, input string name);
        applyStimulus(v);
        checkOutput(v, name);
    endtask

    task automatic doReset(input string name);
        rst            = 1'b1;
        start          = 1'b0;
        init_load_done = 1'b0;
        status_in      = '0;
        key_read_done  = '0;
        in_write_done  = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput(mk(0,0,ST_NONE,0,0, 5'd0,0,0,0,0,0,0,8'd0,0), name);
        rst = 1'b0;
    endtask

    // Fast boot with init_load_done in the first INIT_LOAD cycle.
    task automatic boot(input string name, input logic [7:0] kr);
        step(mk(1,0,ST_NONE,0,0, 5'd1,0,0,0,0,0,0,kr,0), {name, "_start"});
        step(mk(0,0,ST_NONE,0,0, 5'd2,0,0,1,0,0,0,kr,0), {name, "_load"});
        step(mk(0,1,ST_NONE,0,0, 5'd3,0,0,0,0,0,0,kr,0), {name, "_initend"});
        step(mk(0,0,ST_NONE,0,0, 5'd4,0,0,0,0,1,0,kr,0), {name, "_idlewr"});
        step(mk(0,0,ST_NONE,0,0, 5'd5,0,0,0,0,0,0,kr,0), {name, "_poll"});
    endtask

    initial begin
        // start, ild, status, kd, id | state, ken, ien, ilen, rdy, idl, rc, keys_read, tmo
        tbl.push_back(mk(1,0,ST_NONE, 2'b00,4'b0000, 5'd1, 2'b00,4'b0000,0,0,0,0,8'd0,0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0,0,ST_NONE, 2'b00,4'b0000, 5'd2, 2'b00,4'b0000,1,0,0,0,8'd0,0));
        tbl.push_back(mk(0,1,ST_NONE, 2'b00,4'b0000, 5'd3,  2'b00,4'b0000,0,0,0,0,8'd0,0));
        tbl.push_back(mk(0,0,ST_NONE, 2'b00,4'b0000, 5'd4,  2'b00,4'b0000,0,0,1,0,8'd0,0));
        tbl.push_back(mk(0,0,ST_NONE, 2'b00,4'b0000, 5'd5,  2'b00,4'b0000,0,0,0,0,8'd0,0));
        tbl.push_back(mk(0,0,ST_NONE, 2'b00,4'b0000, 5'd5,  2'b00,4'b0000,0,0,0,0,8'd0,0));
        tbl.push_back(mk(0,0,ST_BOTH, 2'b00,4'b0000, 5'd6,  2'b01,4'b0000,0,0,0,0,8'd0,0));
        tbl.push_back(mk(0,0,ST_BOTH, 2'b10,4'b0000, 5'd6,  2'b01,4'b0000,0,0,0,0,8'd0,0));
        tbl.push_back(mk(0,0,ST_BOTH, 2'b01,4'b0000, 5'd7,  2'b00,4'b0000,0,0,0,0,8'd0,0));
        tbl.push_back(mk(0,0,ST_WIDLE,2'b00,4'b0000, 5'd10, 2'b00,4'b0000,0,1,0,0,8'd1,0));
        tbl.push_back(mk(0,0,ST_WBUSY,2'b00,4'b0000, 5'd11, 2'b00,4'b0000,0,0,0,0,8'd1,0));
        tbl.push_back(mk(0,0,ST_WBUSY,2'b00,4'b0000, 5'd11, 2'b00,4'b0000,0,0,0,0,8'd1,0));
        tbl.push_back(mk(0,0,ST_WIDLE,2'b00,4'b0000, 5'd12, 2'b00,4'b0000,0,0,1,0,8'd1,0));
        tbl.push_back(mk(0,0,ST_NONE, 2'b00,4'b0000, 5'd13, 2'b00,4'b0000,0,0,0,1,8'd1,0));
        tbl.push_back(mk(0,0,ST_NONE, 2'b00,4'b0000, 5'd0,  2'b00,4'b0000,0,0,0,0,8'd1,0));
        tbl.push_back(mk(1,0,ST_NONE, 2'b00,4'b0000, 5'd1,  2'b00,4'b0000,0,0,0,0,8'd1,0));
        tbl.push_back(mk(0,0,ST_NONE, 2'b00,4'b0000, 5'd2,  2'b00,4'b0000,1,0,0,0,8'd1,0));
        tbl.push_back(mk(0,1,ST_NONE, 2'b00,4'b0000, 5'd3,  2'b00,4'b0000,0,0,0,0,8'd1,0));
        tbl.push_back(mk(0,0,ST_NONE, 2'b00,4'b0000, 5'd4,  2'b00,4'b0000,0,0,1,0,8'd1,0));
        tbl.push_back(mk(0,0,ST_NONE, 2'b00,4'b0000, 5'd5,  2'b00,4'b0000,0,0,0,0,8'd1,0));
        tbl.push_back(mk(0,0,ST_BOTH, 2'b00,4'b0000, 5'd6,  2'b10,4'b0000,0,0,0,0,8'd1,0));
        tbl.push_back(mk(0,0,ST_BOTH, 2'b10,4'b0000, 5'd7,  2'b00,4'b0000,0,0,0,0,8'd1,0));
        tbl.push_back(mk(0,0,ST_BOTH, 2'b00,4'b0000, 5'd30, 2'b00,4'b0000,0,0,0,0,8'd2,0));
        tbl.push_back(mk(1,0,ST_BOTH, 2'b00,4'b0000, 5'd30, 2'b00,4'b0000,0,0,0,0,8'd2,0));

        doReset("reset_state");
        foreach (tbl[i]) begin
            applyStimulus(tbl[i]);
            checkOutput(tbl[i], $sformatf("table[%0d]", i));
        end

        // Key request beats input request; KEY_END then hands off to input ch3.
        doReset("prio_reset");
        boot("prio", 8'd0);
        step(mk(0,0,ST_PRIO,2'b00,4'b0000, 5'd6, 2'b01,4'b0000,0,0,0,0,8'd0,0), "prio_key");
        step(mk(0,0,ST_PRIO,2'b01,4'b0000, 5'd7, 2'b00,4'b0000,0,0,0,0,8'd0,0), "prio_keyend");
        step(mk(0,0,ST_PRIO,2'b00,4'b0000, 5'd8, 2'b00,4'b1000,0,0,0,0,8'd1,0), "prio_inwrite");
        step(mk(0,0,ST_PRIO,2'b00,4'b0001, 5'd8, 2'b00,4'b1000,0,0,0,0,8'd1,0), "prio_wrong_done");

        // Asynchronous reset in the middle of IN_WRITE, away from any edge.
        #3;
        rst = 1'b1;
        #1;
        checkOutput(mk(0,0,ST_NONE,0,0, 5'd0,0,0,0,0,0,0,8'd0,0), "async_reset");
        start = 1'b0; status_in = '0; key_read_done = '0; in_write_done = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // No done: ERROR after the 16th KEY_READ cycle.
        doReset("tmo_reset");
        boot("tmo", 8'd0);
        step(mk(0,0,ST_BOTH,2'b00,4'b0000, 5'd6, 2'b01,4'b0000,0,0,0,0,8'd0,0), "tmo_grant");
        for (int c = 2; c <= 16; c++)
            step(mk(0,0,ST_BOTH,2'b00,4'b0000, 5'd6, 2'b01,4'b0000,0,0,0,0,8'd0,0),
                 $sformatf("tmo_wait%0d", c - 1));
        step(mk(0,0,ST_BOTH,2'b00,4'b0000, 5'd31, 2'b00,4'b0000,0,0,0,0,8'd0,1), "tmo_error");
        step(mk(1,0,ST_BOTH,2'b01,4'b0000, 5'd31, 2'b00,4'b0000,0,0,0,0,8'd0,1), "tmo_sticky");

        // Done arriving in the 16th cycle wins over the timeout.
        doReset("tmo2_reset");
        boot("tmo2", 8'd0);
        step(mk(0,0,ST_BOTH,2'b00,4'b0000, 5'd6, 2'b01,4'b0000,0,0,0,0,8'd0,0), "tmo2_grant");
        for (int c = 2; c <= 16; c++)
            step(mk(0,0,ST_BOTH,2'b00,4'b0000, 5'd6, 2'b01,4'b0000,0,0,0,0,8'd0,0),
                 $sformatf("tmo2_wait%0d", c - 1));
        step(mk(0,0,ST_BOTH, 2'b01,4'b0000, 5'd7,  2'b00,4'b0000,0,0,0,0,8'd0,0), "tmo2_keyend");
        step(mk(0,0,ST_WIDLE,2'b00,4'b0000, 5'd10, 2'b00,4'b0000,0,1,0,0,8'd1,0), "tmo2_ready");

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
